avg_sched: RTL and testbench

Multi-channel scheduler that shares one averaging datapath between `N_CH` asynchronous sample sources. Each channel presents a 16-bit sample with an asynchronous data-available strobe. The block synchronizes and captures each sample, then grants the shared averager round-robin. It returns each result to a per-channel output register with a valid pulse. It sits between the sensor/sample front-ends and the averager inside `top`.

---
 rtl/avg_pkg.sv | 17 +
 rtl/avg_in_sync.sv | 52 +++++
 rtl/avg_sched.sv | 167 ++++++++++++++++
 tb/tb_avg_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_pkg.sv
// Shared constants and types for the avg_sched multi-channel averaging scheduler.
package avg_pkg;

    localparam int unsigned DW     = 16;
    localparam int unsigned RW     = 32;
    localparam int unsigned MAX_CH = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE
    } sched_state_t;

    typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/avg_in_sync.sv
// Per-channel front end: 2-flop synchronizer plus edge-detect flop, sample hold register,
// pending bit and sticky overrun flag.
module avg_in_sync
    import avg_pkg::*;
#(
    parameter int unsigned DW = avg_pkg::DW
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          av_ai,
    input  logic [DW-1:0] data_i,
    input  logic          take_i,
    input  logic          ovr_clr_i,
    output logic [DW-1:0] hold_o,
    output logic          pend_o,
    output logic          ovr_o
);

    logic [2:0]    sync_q, sync_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          pend_q, pend_d;
    logic          ovr_q, ovr_d;
    logic          rise;

    always_comb begin
        sync_d = {sync_q[1:0], av_ai};
        rise   = sync_q[1] & ~sync_q[2];
        hold_d = rise ? data_i : hold_q;
        // A new edge coinciding with the grant keeps the bit set and is not an overrun.
        pend_d = rise | (pend_q & ~take_i);
        ovr_d  = (rise & pend_q & ~take_i) | (ovr_q & ~ovr_clr_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
            hold_q <= '0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hold_q <= hold_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign hold_o = hold_q;
    assign pend_o = pend_q;
    assign ovr_o  = ovr_q;

endmodule

// File: rtl/avg_sched.sv
// Round-robin scheduler sharing one averager among N_CH asynchronous sample sources.
// Optional WAIT-state timeout enabled by defining AVG_SCHED_TIMEOUT_EN.
module avg_sched
    import avg_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned DW   = avg_pkg::DW,
    parameter int unsigned RW   = avg_pkg::RW
`ifdef AVG_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 255
`endif
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [N_CH*DW-1:0]       ch_data_i,
    input  logic [N_CH-1:0]          ch_av_ai,
    output logic [DW-1:0]            dp_data_o,
    output logic [$clog2(N_CH)-1:0]  dp_ch_o,
    output logic                     dp_start_o,
    input  logic                     dp_done_i,
    input  logic [RW-1:0]            dp_avg_i,
    output logic [N_CH*RW-1:0]       avg_o,
    output logic [N_CH-1:0]          avg_valid_o,
    output logic [N_CH-1:0]          overrun_o,
    input  logic [N_CH-1:0]          ovr_clr_i
`ifdef AVG_SCHED_TIMEOUT_EN
    ,
    output logic                     timeout_o
`endif
);

    localparam int unsigned CW = $clog2(N_CH);

    sched_state_t        state_q, state_d;
    logic [CW-1:0]       grant_q, grant_d;
    logic [CW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       next_ptr;
    logic [CW-1:0]       rr_sel;
    logic                rr_hit;
    int unsigned         idx;
    logic [DW-1:0]       dp_data_q, dp_data_d;
    logic [N_CH*RW-1:0]  avg_q, avg_d;
    logic [N_CH-1:0]     pend;
    logic [N_CH-1:0]     take;
    logic [N_CH*DW-1:0]  hold;
    logic [DW-1:0]       hold_sel;
`ifdef AVG_SCHED_TIMEOUT_EN
    logic [7:0]          tmo_cnt_q, tmo_cnt_d;
    logic                timeout_q, timeout_d;
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        avg_in_sync #(
            .DW(DW)
        ) u_in (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .av_ai    (ch_av_ai[c]),
            .data_i   (ch_data_i[c*DW +: DW]),
            .take_i   (take[c]),
            .ovr_clr_i(ovr_clr_i[c]),
            .hold_o   (hold[c*DW +: DW]),
            .pend_o   (pend[c]),
            .ovr_o    (overrun_o[c])
        );
    end

    assign hold_sel = hold[grant_q*DW +: DW];
    assign next_ptr = (grant_q == CW'(N_CH - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        rr_sel = rr_ptr_q;
        rr_hit = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = (32'(rr_ptr_q) + i) % N_CH;
            if (!rr_hit && pend[idx]) begin
                rr_hit = 1'b1;
                rr_sel = CW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        dp_data_d   = dp_data_q;
        avg_d       = avg_q;
        take        = '0;
        avg_valid_o = '0;
        dp_start_o  = 1'b0;
`ifdef AVG_SCHED_TIMEOUT_EN
        timeout_d   = timeout_q;
        tmo_cnt_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (rr_hit) begin
                    grant_d = rr_sel;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                dp_start_o    = 1'b1;
                take[grant_q] = 1'b1;
                dp_data_d     = hold_sel;
                state_d       = WAIT;
            end
            WAIT: begin
                if (dp_done_i) begin
                    avg_d[grant_q*RW +: RW] = dp_avg_i;
                    state_d = WRITE;
                end
`ifdef AVG_SCHED_TIMEOUT_EN
                else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            WRITE: begin
                avg_valid_o[grant_q] = 1'b1;
                rr_ptr_d = next_ptr;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            dp_data_q <= '0;
            avg_q     <= '0;
`ifdef AVG_SCHED_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            dp_data_q <= dp_data_d;
            avg_q     <= avg_d;
`ifdef AVG_SCHED_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Grant only changes on entry to ISSUE, so it doubles as the held channel index.
    assign dp_ch_o   = grant_q;
    assign dp_data_o = (state_q == ISSUE) ? hold_sel : dp_data_q;
    assign avg_o     = avg_q;
`ifdef AVG_SCHED_TIMEOUT_EN
    assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_avg_sched.sv
// Scoreboard bench for avg_sched with a 3-cycle stub averager; covers the timeout
// scenario when AVG_SCHED_TIMEOUT_EN is defined.
module tb_avg_sched;

    localparam int unsigned NCH = 4;

    typedef struct {
        int unsigned ch;
        logic [15:0] data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b1;
    logic [NCH-1:0][15:0]  ch_data;
    logic [NCH-1:0]        ch_av;
    logic [15:0]           dp_data;
    logic [1:0]            dp_ch;
    logic                  dp_start;
    logic                  dp_done;
    logic [31:0]           dp_avg;
    logic [NCH*32-1:0]     avg_o;
    logic [NCH-1:0]        avg_valid;
    logic [NCH-1:0]        overrun;
    logic [NCH-1:0]        ovr_clr;
`ifdef AVG_SCHED_TIMEOUT_EN
    logic                  timeout;
`endif

    logic [2:0]  stub_pipe;
    logic [15:0] stub_data;
    logic        stub_en;

    exp_t        iss_q[$];
    exp_t        res_q[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned n_start = 0;
    int unsigned n_valid = 0;

    always #5 clk = ~clk;

    avg_sched #(
        .N_CH(NCH),
        .DW  (16),
        .RW  (32)
`ifdef AVG_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT(16)
`endif
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .ch_data_i  (ch_data),
        .ch_av_ai   (ch_av),
        .dp_data_o  (dp_data),
        .dp_ch_o    (dp_ch),
        .dp_start_o (dp_start),
        .dp_done_i  (dp_done),
        .dp_avg_i   (dp_avg),
        .avg_o      (avg_o),
        .avg_valid_o(avg_valid),
        .overrun_o  (overrun),
        .ovr_clr_i  (ovr_clr)
`ifdef AVG_SCHED_TIMEOUT_EN
        ,
        .timeout_o  (timeout)
`endif
    );

    // Stub averager: done three cycles after start, result = zero-extended sample.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stub_pipe <= '0;
            stub_data <= '0;
        end else begin
            stub_pipe <= {stub_pipe[1:0], dp_start};
            if (dp_start) stub_data <= dp_data;
        end
    end
    assign dp_done = stub_pipe[2] & stub_en;
    assign dp_avg  = {16'h0000, stub_data};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (dp_start) begin
            n_start++;
            if (iss_q.size() == 0) begin
                chk("unexpected_start", 32'(dp_start), 32'd0);
            end else begin
                e = iss_q.pop_front();
                chk("issue_ch", 32'(dp_ch), e.ch);
                chk("issue_data", 32'(dp_data), 32'(e.data));
                if (stub_en) res_q.push_back(e);
            end
        end
        if (avg_valid != '0) begin
            n_valid++;
            if (res_q.size() == 0) begin
                chk("unexpected_valid", 32'(avg_valid), 32'd0);
            end else begin
                e = res_q.pop_front();
                chk("valid_vec", 32'(avg_valid), 32'd1 << e.ch);
                chk("avg_result", avg_o[e.ch*32 +: 32], 32'(e.data));
            end
        end
    end

    task automatic expect_iss(input int unsigned c, input logic [15:0] v);
        exp_t e;
        e.ch   = c;
        e.data = v;
        iss_q.push_back(e);
    endtask

    task automatic pulse(input int unsigned c, input logic [15:0] v);
        ch_data[c] = v;
        ch_av[c]   = 1'b1;
        repeat (2) @(negedge clk);
        ch_av[c]   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic burst(input logic [NCH-1:0] mask, input logic [15:0] v0, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [15:0] v3);
        ch_data = {v3, v2, v1, v0};
        ch_av   = mask;
        repeat (2) @(negedge clk);
        ch_av   = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            if (iss_q.size() == 0 && res_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_timeout", 32'(iss_q.size() + res_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        iss_q.delete();
        res_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_start"}, 32'(dp_start), 32'd0);
        chk({tag, "_data"}, 32'(dp_data), 32'd0);
        chk({tag, "_ch"}, 32'(dp_ch), 32'd0);
        chk({tag, "_avg_nz"}, 32'(avg_o != '0), 32'd0);
        chk({tag, "_valid"}, 32'(avg_valid), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
`ifdef AVG_SCHED_TIMEOUT_EN
        chk({tag, "_tmo"}, 32'(timeout), 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned lat;
        int unsigned ns0;
        int unsigned nv0;
        ch_av   = '0;
        ch_data = '0;
        ovr_clr = '0;
        stub_en = 1'b1;

        // 1: reset state, no stimulus
        #1 rstn = 1'b0;
        #29;
        chk_outputs_zero("t1_rst");
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("t1_no_start", n_start, 32'd0);

        // 2: single sample on ch0, start latency of 4 cycles
        @(negedge clk);
        nv0 = n_valid;
        expect_iss(0, 16'd1500);
        fork
            pulse(0, 16'd1500);
        join_none
        lat = 0;
        for (int unsigned i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (dp_start) begin
                lat = i;
                break;
            end
        end
        chk("t2_latency", lat, 32'd4);
        drain(50);
        chk("t2_avg0", avg_o[31:0], 32'd1500);
        chk("t2_valid_cnt", n_valid - nv0, 32'd1);

        // 3: simultaneous bursts granted 0,1,2,3 twice
        do_reset();
        expect_iss(0, 16'd100);
        expect_iss(1, 16'd10);
        expect_iss(2, 16'd40000);
        expect_iss(3, 16'd300);
        burst(4'b1111, 16'd100, 16'd10, 16'd40000, 16'd300);
        drain(100);
        chk("t3_avg0", avg_o[0*32 +: 32], 32'd100);
        chk("t3_avg1", avg_o[1*32 +: 32], 32'd10);
        chk("t3_avg2", avg_o[2*32 +: 32], 32'd40000);
        chk("t3_avg3", avg_o[3*32 +: 32], 32'd300);
        expect_iss(0, 16'd7);
        expect_iss(1, 16'd8);
        expect_iss(2, 16'd9);
        expect_iss(3, 16'd65535);
        burst(4'b1111, 16'd7, 16'd8, 16'd9, 16'd65535);
        drain(100);
        chk("t3b_avg3", avg_o[3*32 +: 32], 32'd65535);

        // 4: overrun on ch1 while ch0 busy; newest sample issued, then clear
        @(negedge clk);
        expect_iss(0, 16'd2222);
        expect_iss(1, 16'd1100);
        fork
            pulse(0, 16'd2222);
            begin
                @(negedge clk);
                pulse(1, 16'd100);
                pulse(1, 16'd1100);
            end
        join
        chk("t4_ovr_set", 32'(overrun), 32'b0010);
        drain(60);
        chk("t4_avg1", avg_o[1*32 +: 32], 32'd1100);
        chk("t4_ovr_sticky", 32'(overrun), 32'b0010);
        ovr_clr = 4'b0010;
        @(negedge clk);
        ovr_clr = '0;
        chk("t4_ovr_clr", 32'(overrun), 32'd0);

`ifdef AVG_SCHED_TIMEOUT_EN
        // 5: averager never answers ch1; timeout, no result, ch2 issued next
        do_reset();
        stub_en = 1'b0;
        nv0 = n_valid;
        expect_iss(1, 16'h0111);
        expect_iss(2, 16'h0222);
        fork
            burst(4'b0110, 16'd0, 16'h0111, 16'h0222, 16'd0);
        join_none
        lat = 0;
        for (int unsigned i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (dp_start) begin
                lat = i;
                break;
            end
        end
        chk("t5_first_start_seen", 32'(lat != 0), 32'd1);
        repeat (5) @(negedge clk);
        stub_en = 1'b1;
        repeat (11) @(negedge clk);
        chk("t5_tmo_early", 32'(timeout), 32'd0);
        @(negedge clk);
        chk("t5_tmo_set", 32'(timeout), 32'd1);
        chk("t5_no_valid", n_valid - nv0, 32'd0);
        @(negedge clk);
        chk("t5_next_start", 32'(dp_start), 32'd1);
        drain(40);
        chk("t5_avg1_untouched", avg_o[1*32 +: 32], 32'd0);
        chk("t5_avg2", avg_o[2*32 +: 32], 32'h0222);
        chk("t5_tmo_sticky", 32'(timeout), 32'd1);
`endif

        // 6: reset during WAIT with ch2 pending discards everything
        @(negedge clk);
        ns0 = n_start;
        expect_iss(0, 16'd77);
        fork
            pulse(0, 16'd77);
            begin
                @(negedge clk);
                pulse(2, 16'd555);
            end
        join_none
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n_start != ns0) break;
        end
        chk("t6_ch0_started", n_start - ns0, 32'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        iss_q.delete();
        res_q.delete();
        @(negedge clk);
        chk_outputs_zero("t6_rst");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ns0 = n_start;
        nv0 = n_valid;
        repeat (20) @(negedge clk);
        chk("t6_no_start", n_start - ns0, 32'd0);
        chk("t6_no_valid", n_valid - nv0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
